// File: rtl/fc_mac_scheduler.sv
// fc_mac_scheduler
// Control-path sequencer for a fully-connected layer y = ReLU(W*x), W is MxN,
// computed by P parallel MAC lanes. Holds no arithmetic: it streams x into the
// shared x buffer, sweeps the x/ROM addresses for each group of P rows, lines
// the accumulator enables up with the memory+multiply pipeline, and walks the
// output mux across the P lane results through a valid/ready port.
//
// Ports
//   clk, reset       clock; synchronous active-high reset
//   input_valid/ready    x element stream (accepted only while loading)
//   output_valid/ready   lane result handshake (mux selected by lane_sel)
//   addr_x, wr_en_x      x buffer address (write and read) and write enable
//   addr_w               weight ROM address, shared by all lanes
//   clear_acc            zero all lane accumulators
//   en_acc               accumulate the product now at the accumulator input
//   relu_en              clamp negative accumulators to zero (one pulse)
//   lane_sel             output mux select
//   layer_done           pulse on the final output handshake of a vector
module fc_mac_scheduler #(
    parameter int M        = 10,
    parameter int N        = 8,
    parameter int P        = 1,
    parameter int PIPE_LAT = 2
) (
    input  logic                                clk,
    input  logic                                reset,
    input  logic                                input_valid,
    output logic                                input_ready,
    output logic                                output_valid,
    input  logic                                output_ready,
    output logic [$clog2(N)-1:0]                addr_x,
    output logic                                wr_en_x,
    output logic [$clog2((M/P)*N)-1:0]          addr_w,
    output logic                                clear_acc,
    output logic                                en_acc,
    output logic                                relu_en,
    output logic [((P > 1) ? $clog2(P) : 1)-1:0] lane_sel,
    output logic                                layer_done
);

    localparam int G    = M / P;
    localparam int AW_X = $clog2(N);
    localparam int AW_W = $clog2(G * N);
    localparam int AW_L = (P > 1) ? $clog2(P) : 1;
    localparam int GW   = (G > 1) ? $clog2(G) : 1;
    // One counter serves the load count, the EXEC column index and the drain
    // cycle count, so it must reach the larger of N-1 and PIPE_LAT.
    localparam int CW   = $clog2(N + PIPE_LAT + 1);

    localparam logic [CW-1:0]   CNT_N_LAST   = CW'(N - 1);
    localparam logic [CW-1:0]   CNT_DR_LAST  = CW'(PIPE_LAT);
    localparam logic [AW_W-1:0] AW_LAST      = AW_W'(G * N - 1);
    localparam logic [GW-1:0]   G_LAST       = GW'(G - 1);
    localparam logic [AW_L-1:0] LANE_LAST    = AW_L'(P - 1);

    typedef enum logic [1:0] {
        S_LOAD,
        S_EXEC,
        S_DRAIN,
        S_OUT
    } state_t;

    state_t          state_q, state_d;
    logic [CW-1:0]   cnt_q,   cnt_d;
    logic [GW-1:0]   g_q,     g_d;
    logic [AW_L-1:0] lane_q,  lane_d;
    logic [AW_W-1:0] aw_q,    aw_d;
    logic            issue;
    logic [PIPE_LAT-1:0] en_sr_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_LOAD;
            cnt_q   <= '0;
            g_q     <= '0;
            lane_q  <= '0;
            aw_q    <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            g_q     <= g_d;
            lane_q  <= lane_d;
            aw_q    <= aw_d;
        end
    end

    // Issue pulse delayed PIPE_LAT cycles so en_acc meets the product that
    // was addressed that many cycles earlier. Flushed on reset so no stale
    // enable can leak into the next vector.
    always_ff @(posedge clk) begin
        if (reset) begin
            en_sr_q <= '0;
        end else begin
            en_sr_q[0] <= issue;
            for (int i = 1; i < PIPE_LAT; i++) begin
                en_sr_q[i] <= en_sr_q[i-1];
            end
        end
    end

    assign en_acc = en_sr_q[PIPE_LAT-1] & ~reset;

    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        g_d          = g_q;
        lane_d       = lane_q;
        aw_d         = aw_q;
        issue        = 1'b0;
        input_ready  = 1'b0;
        wr_en_x      = 1'b0;
        output_valid = 1'b0;
        clear_acc    = 1'b0;
        relu_en      = 1'b0;
        layer_done   = 1'b0;
        addr_x       = '0;
        addr_w       = aw_q;
        lane_sel     = lane_q;

        case (state_q)
            S_LOAD: begin
                input_ready = 1'b1;
                addr_x      = cnt_q[AW_X-1:0];
                if (input_valid) begin
                    wr_en_x = 1'b1;
                    if (cnt_q == CNT_N_LAST) begin
                        cnt_d   = '0;
                        g_d     = '0;
                        state_d = S_EXEC;
                    end else begin
                        cnt_d = cnt_q + CW'(1);
                    end
                end
            end

            S_EXEC: begin
                addr_x    = cnt_q[AW_X-1:0];
                issue     = 1'b1;
                clear_acc = (cnt_q == '0);
                // Running g*N+k; wraps to 0 after the last row of the layer.
                aw_d      = (aw_q == AW_LAST) ? '0 : aw_q + AW_W'(1);
                if (cnt_q == CNT_N_LAST) begin
                    cnt_d   = '0;
                    state_d = S_DRAIN;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end

            S_DRAIN: begin
                // The last delayed en_acc lands one cycle before this phase
                // ends, so ReLU fires on the final drain cycle.
                if (cnt_q == CNT_DR_LAST) begin
                    relu_en = 1'b1;
                    cnt_d   = '0;
                    lane_d  = '0;
                    state_d = S_OUT;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end

            S_OUT: begin
                output_valid = 1'b1;
                if (output_ready) begin
                    if (lane_q == LANE_LAST) begin
                        lane_d = '0;
                        if (g_q == G_LAST) begin
                            layer_done = 1'b1;
                            g_d        = '0;
                            state_d    = S_LOAD;
                        end else begin
                            g_d     = g_q + GW'(1);
                            state_d = S_EXEC;
                        end
                    end else begin
                        lane_d = lane_q + AW_L'(1);
                    end
                end
            end

            default: state_d = S_LOAD;
        endcase

        // Outputs read as idle for the whole reset cycle, whatever the state.
        if (reset) begin
            input_ready  = 1'b0;
            wr_en_x      = 1'b0;
            output_valid = 1'b0;
            clear_acc    = 1'b0;
            relu_en      = 1'b0;
            layer_done   = 1'b0;
            addr_x       = '0;
            addr_w       = '0;
            lane_sel     = '0;
            issue        = 1'b0;
        end
    end

endmodule
